// File: rtl/fifo_pkg.sv
// Shared sizing defaults and state typedefs for the sync_fifo slice.
package fifo_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int AFULL_LV = DEPTH - 1;

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [ADDR_W:0]   count_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write port, registered read port.
// Only the read register is reset; the array itself is left as-is.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int ADDR_W = fifo_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  // Read-before-write on a shared address: the full R+W case relies on this.
  always_ff @(posedge clk) begin
    if (!rst)    dout <= '0;
    else if (re) dout <= mem[raddr];
  end
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and status/error flags.
// Define FIFO_STICKY_ERR_EN to make OVER/UNDER latch until reset.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = fifo_pkg::DATA_W,
  parameter int ADDR_W   = fifo_pkg::ADDR_W,
  parameter int AFULL_LV = fifo_pkg::AFULL_LV
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR,
  input  logic              RD,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              almostFULL,
  output logic              FULL,
  output logic              OVER,
  output logic              EMPTY,
  output logic              UNDER,
  output logic              VALID
);
  localparam logic [ADDR_W:0]   CNT_DEPTH = (ADDR_W+1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0]   CNT_AFULL = (ADDR_W+1)'(AFULL_LV);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   count;
  logic              rd_ok, wr_ok, ovf, udf;

  assign EMPTY      = (count == '0);
  assign FULL       = (count == CNT_DEPTH);
  assign almostFULL = (count >= CNT_AFULL);

  // A read frees a slot in the same edge, so a full FIFO still takes a write alongside it.
  assign rd_ok = RD & ~EMPTY;
  assign wr_ok = WR & (~FULL | RD);
  assign ovf   = WR & FULL & ~RD;
  assign udf   = RD & EMPTY;

  sync_fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (CLK),
    .rst   (RST),
    .we    (wr_ok),
    .waddr (wptr),
    .din   (DIN),
    .re    (rd_ok),
    .raddr (rptr),
    .dout  (DOUT)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      VALID <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_ONE;
      if (rd_ok) rptr <= rptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      VALID <= rd_ok;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      OVER  <= 1'b0;
      UNDER <= 1'b0;
    end else begin
`ifdef FIFO_STICKY_ERR_EN
      OVER  <= OVER  | ovf;
      UNDER <= UNDER | udf;
`else
      OVER  <= ovf;
      UNDER <= udf;
`endif
    end
  end
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reset, overflow, drain, and simultaneous R+W corners.
module tb_sync_fifo;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        WR  = 1'b0;
  logic        RD  = 1'b0;
  logic [15:0] DIN = '0;
  logic [15:0] DOUT;
  logic        almostFULL, FULL, OVER, EMPTY, UNDER, VALID;

  int checks   = 0;
  int failures = 0;

  sync_fifo dut (
    .CLK(CLK), .RST(RST), .WR(WR), .RD(RD), .DIN(DIN), .DOUT(DOUT),
    .almostFULL(almostFULL), .FULL(FULL), .OVER(OVER),
    .EMPTY(EMPTY), .UNDER(UNDER), .VALID(VALID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply the current inputs across one rising edge, then settle before sampling.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic flags(input string tag, input logic e, input logic af, input logic f);
    chk({tag, ".EMPTY"}, 32'(EMPTY), 32'(e));
    chk({tag, ".almostFULL"}, 32'(almostFULL), 32'(af));
    chk({tag, ".FULL"}, 32'(FULL), 32'(f));
  endtask

  task automatic do_reset();
    RST = 1'b0; WR = 1'b0; RD = 1'b0;
    repeat (10) step();
    RST = 1'b1;
  endtask

  task automatic overflow_run();
    for (int i = 1; i <= 10; i++) begin
      WR = 1'b1; DIN = 16'(i);
      step();
      flags($sformatf("ovf.w%0d", i), 1'b0, i >= 7, i >= 8);
      chk($sformatf("ovf.w%0d.OVER", i), 32'(OVER), 32'(i >= 9));
    end
    WR = 1'b0;
  endtask

  logic [15:0] drain_exp [10] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5,
                                  16'd6, 16'd7, 16'd8, 16'd11, 16'd12};

  initial begin
    // reset state
    do_reset();
    flags("rst", 1'b1, 1'b0, 1'b0);
    chk("rst.OVER", 32'(OVER), 0);
    chk("rst.UNDER", 32'(UNDER), 0);
    chk("rst.VALID", 32'(VALID), 0);
    chk("rst.DOUT", 32'(DOUT), 0);

    // fill past capacity; 9 and 10 dropped
    overflow_run();
    step();
    flags("ovf.idle", 1'b0, 1'b1, 1'b1);
`ifdef FIFO_STICKY_ERR_EN
    chk("ovf.idle.OVER", 32'(OVER), 1);
    repeat (3) step();
    chk("ovf.sticky.OVER", 32'(OVER), 1);
    do_reset();
    chk("ovf.clr.OVER", 32'(OVER), 0);
    overflow_run();
    step();
`else
    chk("ovf.idle.OVER", 32'(OVER), 0);
`endif

    // drain with two mixed R+W, then two underflows
    for (int k = 1; k <= 12; k++) begin
      RD = 1'b1;
      WR = (k == 4 || k == 5);
      DIN = (k == 4) ? 16'd11 : 16'd12;
      step();
      if (k <= 10) begin
        chk($sformatf("drn.r%0d.DOUT", k), 32'(DOUT), 32'(drain_exp[k-1]));
        chk($sformatf("drn.r%0d.VALID", k), 32'(VALID), 1);
        chk($sformatf("drn.r%0d.UNDER", k), 32'(UNDER), 0);
      end else begin
        chk($sformatf("drn.r%0d.DOUT", k), 32'(DOUT), 32'd12);
        chk($sformatf("drn.r%0d.VALID", k), 32'(VALID), 0);
        chk($sformatf("drn.r%0d.UNDER", k), 32'(UNDER), 1);
      end
    end
    RD = 1'b0; WR = 1'b0;
    step();
    flags("drn.end", 1'b1, 1'b0, 1'b0);
`ifndef FIFO_STICKY_ERR_EN
    chk("drn.end.UNDER", 32'(UNDER), 0);
`endif
    chk("drn.end.VALID", 32'(VALID), 0);

    // empty + R + W: read rejected, write lands
    RD = 1'b1; WR = 1'b1; DIN = 16'h0055;
    step();
    chk("erw.UNDER", 32'(UNDER), 1);
    chk("erw.VALID", 32'(VALID), 0);
    chk("erw.DOUT", 32'(DOUT), 32'd12);
    flags("erw", 1'b0, 1'b0, 1'b0);
    RD = 1'b0;

    // bring count to 7
    for (int i = 0; i < 6; i++) begin
      DIN = 16'h0060 + 16'(i);
      step();
    end
    WR = 1'b0;
    step();
    flags("af.pre", 1'b0, 1'b1, 1'b0);

    // almost-full + R + W: count holds at 7
    RD = 1'b1; WR = 1'b1; DIN = 16'h0066;
    step();
    RD = 1'b0; WR = 1'b0;
    chk("afrw.DOUT", 32'(DOUT), 32'h55);
    chk("afrw.VALID", 32'(VALID), 1);
    step();
    flags("afrw", 1'b0, 1'b1, 1'b0);

    // top up to full, then full + R + W
    WR = 1'b1; DIN = 16'h0067;
    step();
    WR = 1'b0;
    flags("full.pre", 1'b0, 1'b1, 1'b1);
    RD = 1'b1; WR = 1'b1; DIN = 16'h0068;
    step();
    RD = 1'b0; WR = 1'b0;
    chk("frw.DOUT", 32'(DOUT), 32'h60);
    chk("frw.VALID", 32'(VALID), 1);
    chk("frw.OVER", 32'(OVER), 0);
    chk("frw.FULL", 32'(FULL), 1);

    // reset mid-operation empties the FIFO
    RST = 1'b0;
    step();
    RST = 1'b1;
    flags("mrst", 1'b1, 1'b0, 1'b0);
    chk("mrst.DOUT", 32'(DOUT), 0);
    chk("mrst.VALID", 32'(VALID), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
